// File: rtl/sim_test_monitor_if.sv
// Retire and store observation bus from up to NHART cores into the test monitor.
// The core side drives (master); the monitor only listens (slave).
interface sim_test_monitor_if #(
   parameter int XLEN   = 32,
   parameter int AWIDTH = 14,
   parameter int NHART  = 2
);
   logic [NHART-1:0]        ret_valid;
   logic [NHART*XLEN-1:0]   ret_inst;
   logic [NHART*XLEN-1:0]   gp_val;
   logic [NHART-1:0]        st_valid;
   logic [NHART*AWIDTH-1:0] st_addr;
   logic [NHART*XLEN-1:0]   st_wdata;

   modport master (
      output ret_valid, ret_inst, gp_val, st_valid, st_addr, st_wdata
   );

   modport slave (
      input ret_valid, ret_inst, gp_val, st_valid, st_addr, st_wdata
   );
endinterface

// File: rtl/sim_test_monitor.sv
// Per-hart test completion monitor: decides PASS/FAIL/TIMEOUT from ECALL/EBREAK
// retires and tohost stores, and reports a global verdict plus counters.
module sim_test_monitor #(
   parameter int          XLEN        = 32,
   parameter int          AWIDTH      = 14,
   parameter int          NHART       = 2,
   parameter int          HID_W       = 2,
   parameter int          CNT_W       = 32,
   parameter int          TIMEOUT     = 5000,
   parameter bit          TOHOST_EN   = 1'b1,
   parameter logic [31:0] TOHOST_ADDR = 32'h1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   sim_test_monitor_if.slave       mon,
   output logic [NHART*3-1:0]      hart_state,
   output logic                    done,
   output logic                    pass,
   output logic [XLEN-1:0]         fail_code,
   output logic [HID_W-1:0]        fail_hart,
   output logic [CNT_W-1:0]        cycle_cnt,
   output logic [NHART*CNT_W-1:0]  ret_cnt
);

   // state    | meaning
   // ST_IDLE  | not armed, events ignored, not counting
   // ST_RUN   | armed, watching for tohost / ECALL / EBREAK / timeout
   // ST_PASS  | terminal, test passed
   // ST_FAIL  | terminal, failed with captured code
   // ST_TMO   | terminal, cycle limit reached (code all-ones)
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_PASS = 3'd2,
      ST_FAIL = 3'd3,
      ST_TMO  = 3'd4
   } state_e;

   localparam logic [XLEN-1:0] INST_ECALL  = XLEN'(32'h0000_0073);
   localparam logic [XLEN-1:0] INST_EBREAK = XLEN'(32'h0010_0073);
   localparam logic [XLEN-1:0] ONE_X       = XLEN'(1);

   state_e            state_q   [NHART];
   state_e            state_d   [NHART];
   logic [XLEN-1:0]   code_q    [NHART];
   logic [XLEN-1:0]   code_d    [NHART];
   logic [CNT_W-1:0]  ret_cnt_q [NHART];
   logic [CNT_W-1:0]  ret_cnt_d [NHART];
   logic [CNT_W-1:0]  cycle_cnt_q;
   logic [CNT_W-1:0]  cycle_cnt_d;
   logic              any_run;
   logic              found;

   always_comb begin
      any_run = 1'b0;
      for (int h = 0; h < NHART; h++) begin
         if (state_q[h] == ST_RUN) any_run = 1'b1;
      end

      cycle_cnt_d = cycle_cnt_q;
      if (start) begin
         cycle_cnt_d = '0;
      end else if (any_run && (cycle_cnt_q != '1)) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end

      for (int h = 0; h < NHART; h++) begin
         state_d[h]   = state_q[h];
         code_d[h]    = code_q[h];
         ret_cnt_d[h] = ret_cnt_q[h];
         if (start) begin
            state_d[h]   = ST_RUN;
            code_d[h]    = '0;
            ret_cnt_d[h] = '0;
         end else if (state_q[h] == ST_RUN) begin
            if (mon.ret_valid[h] && (ret_cnt_q[h] != '1)) begin
               ret_cnt_d[h] = ret_cnt_q[h] + CNT_W'(1);
            end
            // Even tohost values are syscall-proxy requests, not verdicts, so they fall through.
            if (TOHOST_EN && mon.st_valid[h] &&
                (mon.st_addr[h*AWIDTH +: AWIDTH] == AWIDTH'(TOHOST_ADDR)) &&
                (mon.st_wdata[h*XLEN +: XLEN] == ONE_X)) begin
               state_d[h] = ST_PASS;
            end else if (TOHOST_EN && mon.st_valid[h] &&
                         (mon.st_addr[h*AWIDTH +: AWIDTH] == AWIDTH'(TOHOST_ADDR)) &&
                         mon.st_wdata[h*XLEN]) begin
               state_d[h] = ST_FAIL;
               code_d[h]  = mon.st_wdata[h*XLEN +: XLEN];
            end else if (mon.ret_valid[h] && (mon.ret_inst[h*XLEN +: XLEN] == INST_ECALL)) begin
               if (mon.gp_val[h*XLEN +: XLEN] == ONE_X) begin
                  state_d[h] = ST_PASS;
               end else begin
                  state_d[h] = ST_FAIL;
                  code_d[h]  = mon.gp_val[h*XLEN +: XLEN];
               end
            end else if (mon.ret_valid[h] && (mon.ret_inst[h*XLEN +: XLEN] == INST_EBREAK)) begin
               state_d[h] = ST_FAIL;
               code_d[h]  = mon.gp_val[h*XLEN +: XLEN];
            end else if (cycle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d[h] = ST_TMO;
               code_d[h]  = '1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         for (int h = 0; h < NHART; h++) begin
            state_q[h]   <= ST_IDLE;
            code_q[h]    <= '0;
            ret_cnt_q[h] <= '0;
         end
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         for (int h = 0; h < NHART; h++) begin
            state_q[h]   <= state_d[h];
            code_q[h]    <= code_d[h];
            ret_cnt_q[h] <= ret_cnt_d[h];
         end
      end
   end

   // Verdict is purely combinational from registered state, so it moves with hart_state.
   always_comb begin
      hart_state = '0;
      ret_cnt    = '0;
      done       = 1'b1;
      pass       = 1'b1;
      fail_code  = '0;
      fail_hart  = '0;
      found      = 1'b0;
      for (int h = 0; h < NHART; h++) begin
         hart_state[h*3 +: 3]     = state_q[h];
         ret_cnt[h*CNT_W +: CNT_W] = ret_cnt_q[h];
         if ((state_q[h] == ST_IDLE) || (state_q[h] == ST_RUN)) done = 1'b0;
         if (state_q[h] != ST_PASS) pass = 1'b0;
         if (!found && ((state_q[h] == ST_FAIL) || (state_q[h] == ST_TMO))) begin
            found     = 1'b1;
            fail_code = code_q[h];
            fail_hart = HID_W'(h);
         end
      end
      pass = pass & done;
   end

   assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Directed bench for sim_test_monitor (NHART=2, TIMEOUT=100); expectations queued
// by the stimulus process and compared by an independent negedge monitor.
module tb_sim_test_monitor;

   localparam int XLEN = 32;
   localparam int AW   = 14;
   localparam int NH   = 2;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RUN  = 3'd1;
   localparam logic [2:0] S_PASS = 3'd2;
   localparam logic [2:0] S_FAIL = 3'd3;
   localparam logic [2:0] S_TMO  = 3'd4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [NH*3-1:0]      hart_state;
   logic                 done;
   logic                 pass;
   logic [XLEN-1:0]      fail_code;
   logic [1:0]           fail_hart;
   logic [31:0]          cycle_cnt;
   logic [NH*32-1:0]     ret_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [5:0]  hs;
      logic        dn;
      logic        ps;
      logic [31:0] fc;
      logic [1:0]  fh;
      logic [31:0] cc;
      logic [63:0] rc;
   } exp_t;

   exp_t sb_q[$];

   sim_test_monitor_if #(.XLEN(XLEN), .AWIDTH(AW), .NHART(NH)) bus ();

   sim_test_monitor #(
      .XLEN(XLEN), .AWIDTH(AW), .NHART(NH), .HID_W(2), .CNT_W(32),
      .TIMEOUT(100), .TOHOST_EN(1'b1), .TOHOST_ADDR(32'h1000)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mon(bus),
      .hart_state(hart_state), .done(done), .pass(pass),
      .fail_code(fail_code), .fail_hart(fail_hart),
      .cycle_cnt(cycle_cnt), .ret_cnt(ret_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (hart_state !== e.hs || done !== e.dn || pass !== e.ps || fail_code !== e.fc ||
             fail_hart !== e.fh || cycle_cnt !== e.cc || ret_cnt !== e.rc) begin
            errors++;
            $display("FAIL %s: got hs=%h done=%b pass=%b fc=%h fh=%0d cc=%0d rc=%h ; want hs=%h done=%b pass=%b fc=%h fh=%0d cc=%0d rc=%h",
                     e.name, hart_state, done, pass, fail_code, fail_hart, cycle_cnt, ret_cnt,
                     e.hs, e.dn, e.ps, e.fc, e.fh, e.cc, e.rc);
         end
      end
   end

   task automatic expect_out(input string n, input logic [2:0] s0, input logic [2:0] s1,
                             input logic dn, input logic ps, input logic [31:0] fc,
                             input logic [1:0] fh, input logic [31:0] cc,
                             input logic [31:0] rc0, input logic [31:0] rc1);
      exp_t e;
      e.name = n; e.hs = {s1, s0}; e.dn = dn; e.ps = ps; e.fc = fc; e.fh = fh;
      e.cc = cc; e.rc = {rc1, rc0};
      sb_q.push_back(e);
   endtask

   task automatic clear_bus();
      bus.ret_valid = '0; bus.ret_inst = '0; bus.gp_val = '0;
      bus.st_valid  = '0; bus.st_addr  = '0; bus.st_wdata = '0;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         clear_bus();
      end
   endtask

   task automatic retire(input int h, input logic [31:0] inst, input logic [31:0] gp);
      bus.ret_valid[h] = 1'b1;
      bus.ret_inst[h*XLEN +: XLEN] = inst;
      bus.gp_val[h*XLEN +: XLEN]   = gp;
   endtask

   task automatic store(input int h, input logic [13:0] addr, input logic [31:0] wdata);
      bus.st_valid[h] = 1'b1;
      bus.st_addr[h*AW +: AW]       = addr;
      bus.st_wdata[h*XLEN +: XLEN]  = wdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      clear_bus();
      rst = 1'b1;
      start = 1'b1;
      retire(0, 32'h73, 32'h5);
      step(1);
      expect_out("reset_wins", S_IDLE, S_IDLE, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step(1);

      // both harts pass via ECALL gp=1, hart0 retires 3 instructions first
      start = 1'b1;
      step(1);
      expect_out("start_arm", S_RUN, S_RUN, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         retire(0, 32'h0000_0013, 32'h0);
         step(1);
      end
      expect_out("three_retires", S_RUN, S_RUN, 0, 0, 0, 0, 3, 3, 0);
      retire(0, 32'h73, 32'h1);
      retire(1, 32'h73, 32'h1);
      step(1);
      expect_out("ecall_pass_both", S_PASS, S_PASS, 1, 1, 0, 0, 4, 4, 1);
      retire(0, 32'h0010_0073, 32'h9);
      step(2);
      expect_out("pass_sticky", S_PASS, S_PASS, 1, 1, 0, 0, 4, 4, 1);

      // hart0 passes, hart1 fails two cycles later
      start = 1'b1;
      step(1);
      retire(0, 32'h73, 32'h1);
      step(1);
      expect_out("h0_pass_h1_run", S_PASS, S_RUN, 0, 0, 0, 0, 1, 1, 0);
      step(1);
      expect_out("still_waiting", S_PASS, S_RUN, 0, 0, 0, 0, 2, 1, 0);
      retire(1, 32'h73, 32'h7);
      step(1);
      expect_out("h1_fail_code7", S_PASS, S_FAIL, 1, 0, 7, 1, 3, 1, 1);

      // tohost even value is ignored, then 1 passes
      start = 1'b1;
      step(1);
      store(0, 14'h1000, 32'h2);
      step(1);
      expect_out("tohost_even_ignored", S_RUN, S_RUN, 0, 0, 0, 0, 1, 0, 0);
      store(0, 14'h1000, 32'h1);
      step(1);
      expect_out("tohost_one_pass", S_PASS, S_RUN, 0, 0, 0, 0, 2, 0, 0);

      // tohost odd fails; store of 1 to a different address is ignored
      start = 1'b1;
      step(1);
      store(0, 14'h1000, 32'h5);
      store(1, 14'h1004, 32'h1);
      step(1);
      expect_out("tohost_fail5", S_FAIL, S_RUN, 0, 0, 5, 0, 1, 0, 0);
      retire(1, 32'h73, 32'h1);
      step(1);
      expect_out("fail5_done", S_FAIL, S_PASS, 1, 0, 5, 0, 2, 0, 1);

      // timeout at exactly TIMEOUT cycles
      start = 1'b1;
      step(1);
      step(99);
      expect_out("before_timeout", S_RUN, S_RUN, 0, 0, 0, 0, 99, 0, 0);
      step(1);
      expect_out("timeout", S_TMO, S_TMO, 1, 0, 32'hFFFF_FFFF, 0, 100, 0, 0);
      step(3);
      expect_out("cnt_stops_after_tmo", S_TMO, S_TMO, 1, 0, 32'hFFFF_FFFF, 0, 100, 0, 0);

      // ECALL in the timeout cycle beats the timeout
      start = 1'b1;
      step(1);
      step(99);
      retire(0, 32'h73, 32'h1);
      step(1);
      expect_out("ecall_beats_tmo", S_PASS, S_TMO, 1, 0, 32'hFFFF_FFFF, 1, 100, 1, 0);

      // same-cycle priority: tohost 1 beats ECALL gp=3; EBREAK fails hart1
      start = 1'b1;
      step(1);
      store(0, 14'h1000, 32'h1);
      retire(0, 32'h73, 32'h3);
      retire(1, 32'h0010_0073, 32'h9);
      step(1);
      expect_out("tohost_beats_ecall", S_PASS, S_FAIL, 1, 0, 9, 1, 1, 1, 1);

      // even tohost does not mask an ECALL in the same cycle
      start = 1'b1;
      step(1);
      store(0, 14'h1000, 32'h4);
      retire(0, 32'h73, 32'h3);
      store(1, 14'h1000, 32'h1);
      step(1);
      expect_out("even_tohost_ecall_fail", S_FAIL, S_PASS, 1, 0, 3, 0, 1, 1, 0);

      // reset mid-run clears everything
      start = 1'b1;
      step(1);
      retire(0, 32'h73, 32'h1);
      step(1);
      step(3);
      expect_out("pre_reset", S_PASS, S_RUN, 0, 0, 0, 0, 4, 1, 0);
      rst = 1'b1;
      start = 1'b1;
      retire(1, 32'h73, 32'h5);
      step(1);
      expect_out("mid_run_reset", S_IDLE, S_IDLE, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      retire(1, 32'h73, 32'h5);
      step(2);
      expect_out("idle_ignores", S_IDLE, S_IDLE, 0, 0, 0, 0, 0, 0, 0);

      // start mid-run after a pass re-arms and clears counters
      start = 1'b1;
      step(1);
      retire(0, 32'h73, 32'h1);
      step(1);
      step(2);
      expect_out("before_restart", S_PASS, S_RUN, 0, 0, 0, 0, 3, 1, 0);
      start = 1'b1;
      retire(1, 32'h73, 32'h5);
      step(1);
      expect_out("restart", S_RUN, S_RUN, 0, 0, 0, 0, 0, 0, 0);
      step(1);
      expect_out("restart_counting", S_RUN, S_RUN, 0, 0, 0, 0, 1, 0, 0);

      step(2);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sim_test_monitor.md
Name: sim_test_monitor

Overview:
- Synthesizable test-completion monitor for the RockWave core. It observes retired instructions and data stores on up to NHART core instances.
- Per hart, it decides PASS, FAIL or TIMEOUT using riscv-tests conventions: ECALL with gp (x3), or a write to tohost.
- It exposes a global done/pass verdict, a failure code and per-hart counters, so the same check runs in simulation benches and on FPGA.

Parameters:
XLEN, 32, data/instruction width
AWIDTH, 14, data address width
NHART, 2, number of monitored harts (1..4)
HID_W, 2, width of the hart index field
CNT_W, 32, width of the cycle and retire counters
TIMEOUT, 5000, cycle limit after start
TOHOST_EN, 1, 1 enables tohost store detection
TOHOST_ADDR, 'h1000, tohost word address

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; clears counters and arms all harts
ret_valid  in  NHART  hart h retired ret_inst[h] this cycle
ret_inst  in  NHART*XLEN  retired instruction word per hart
gp_val  in  NHART*XLEN  current x3 value per hart
st_valid  in  NHART  hart h issues a store this cycle
st_addr  in  NHART*AWIDTH  store address per hart
st_wdata  in  NHART*XLEN  store data per hart
hart_state  out  NHART*3  per-hart state code
done  out  1  all harts are in a terminal state
pass  out  1  done and every hart is PASS
fail_code  out  XLEN  code of the lowest-index non-PASS hart
fail_hart  out  HID_W  index of that hart
cycle_cnt  out  CNT_W  cycles since start
ret_cnt  out  NHART*CNT_W  retired instructions per hart

Behaviour:
- Reset state: all hart states IDLE(0), all counters 0, done=0, pass=0, fail_code=0, fail_hart=0. Reset wins over every other input in the same cycle.
- State codes: IDLE=0, RUN=1, PASS=2, FAIL=3, TMO=4. PASS, FAIL and TMO are terminal and sticky until rst or start.
- start (any state, including mid-run): all harts go to RUN; cycle_cnt, ret_cnt and the captured codes clear to 0 on the next edge.
- RUN transitions, evaluated per hart at each posedge:
  - tohost store: TOHOST_EN, st_valid, st_addr==TOHOST_ADDR.
    - st_wdata==1 -> PASS.
    - st_wdata odd and !=1 -> FAIL, code=st_wdata.
    - st_wdata even -> ignored (syscall proxy), stay RUN.
  - ECALL retire: ret_valid and ret_inst==32'h00000073.
    - gp_val==1 -> PASS.
    - otherwise -> FAIL, code=gp_val.
  - EBREAK retire: ret_valid and ret_inst==32'h00100073 -> FAIL, code=gp_val.
  - Timeout: cycle_cnt==TIMEOUT-1 while in RUN -> TMO, code=32'hFFFFFFFF.
- Priority within one hart and one cycle: tohost > ECALL/EBREAK > timeout. A termination event always beats a timeout in the same cycle.
- Events outside the RUN state are ignored. IDLE does not count.
- Latency: an event sampled at edge N shows in hart_state after edge N. done, pass, fail_code and fail_hart are combinational from registered state and captured codes, so they update in the same cycle as hart_state.
- cycle_cnt: increments every cycle while any hart is in RUN; saturates at all-ones.
- ret_cnt[h]: increments on ret_valid[h] while hart h is in RUN, including the terminating instruction; saturates at all-ones.
- fail_code/fail_hart: taken from the lowest-index hart in FAIL or TMO. Both are 0 when no hart has failed.
- done: requires all NHART harts to be terminal. pass requires done and every hart in PASS.
- Unused upper bits of multi-hart buses are ignored when NHART < 4.

Test Plan:
- NHART=1: start, 3 retires, then ECALL with gp_val=1 -> state=2 the next cycle, done=1, pass=1, ret_cnt=4, fail_code=0.
- NHART=2: hart0 ECALL gp=1; 2 cycles later hart1 ECALL gp=7 -> done rises only after hart1; pass=0, fail_code=7, fail_hart=1.
- tohost stores on hart0 of wdata 2, then 1 -> after 2 the hart stays RUN; after 1 it goes to PASS. A separate run with wdata 5 -> FAIL, fail_code=5.
- TIMEOUT=100, no events -> TMO with cycle_cnt=100 exactly; fail_code=FFFFFFFF, done=1, pass=0. ECALL gp=1 on cycle 99 -> PASS, not TMO.
- Same-cycle tohost wdata=1 and ECALL gp=3 on one hart -> PASS (tohost wins).
- rst asserted mid-run -> all outputs 0 and states IDLE. start pulse mid-run after one hart PASSed -> all harts back to RUN, counters 0, done=0.
